// File: rtl/scaler_h_ctrl_pkg.sv
// Shared constants and FSM encoding for the horizontal scaler step controller.
package scaler_h_ctrl_pkg;

   localparam int unsigned SCALER_STEP_ONE  = 4096;
   localparam int unsigned SCALER_FRAC_BITS = 12;
   localparam int unsigned SCALER_DIV_BITS  = 28;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

endpackage

// File: rtl/scaler_h_ctrl_div.sv
// Bit-serial restoring divider: 28-bit dividend / 16-bit divisor, one quotient bit per clock.
module scaler_step_div
   import scaler_h_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic [SCALER_DIV_BITS-1:0] dividend_i,
   input  logic [15:0]                divisor_i,
   output logic                       done_o,
   output logic [SCALER_DIV_BITS-1:0] quotient_o
);

   logic [15:0]                rem_q, rem_d;
   logic [SCALER_DIV_BITS-1:0] quo_q, quo_d;
   logic [15:0]                dvs_q;
   logic [4:0]                 cnt_q;
   logic                       run_q;
   logic                       done_q;
   logic                       load;

   logic [15:0]                rem_in;
   logic [SCALER_DIV_BITS-1:0] quo_in;
   logic [15:0]                dvs_in;
   logic [16:0]                trial;

   assign load = start_i & ~run_q;

   // The first quotient bit is produced on the start edge, so 28 bits take 28 edges.
   always_comb begin
      rem_in = load ? 16'd0      : rem_q;
      quo_in = load ? dividend_i : quo_q;
      dvs_in = load ? divisor_i  : dvs_q;
      trial  = {rem_in, quo_in[SCALER_DIV_BITS-1]};
      rem_d  = trial[15:0];
      quo_d  = {quo_in[SCALER_DIV_BITS-2:0], 1'b0};
      if (trial >= {1'b0, dvs_in}) begin
         rem_d  = trial[15:0] - dvs_in;
         quo_d  = {quo_in[SCALER_DIV_BITS-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= divisor_i;
            cnt_q <= 5'(SCALER_DIV_BITS - 1);
            run_q <= 1'b1;
         end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/scaler_h_ctrl.sv
// Horizontal scaler step controller: computes the 4.12 step, holds it until a frame
// boundary, and checks the scaler's reported line length against the applied width.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | no request in flight; length check active on vs
//   DIV     | divider running on latched widths
//   PEND    | step computed, waiting for next vs rising edge
module scaler_h_ctrl
   import scaler_h_ctrl_pkg::*;
#(
   parameter int unsigned STEP_CORD_I = SCALER_STEP_ONE,
   parameter int unsigned FRAC_BITS   = SCALER_FRAC_BITS
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_wr,
   input  logic [15:0] cfg_width_i,
   input  logic [15:0] cfg_width_o,
   input  logic        vs_i,
   input  logic [15:0] pix_count_i,
   output logic [15:0] step_cord_o,
   output logic        busy_o,
   output logic        pend_o,
   output logic        cfg_err_o,
   output logic        len_err_o
);

   state_e      state_q, state_d;
   logic        vs_q;
   logic [15:0] pend_step_q, pend_step_d;
   logic [15:0] pend_wo_q, pend_wo_d;
   logic [15:0] step_q, step_d;
   logic [15:0] applied_wo_q, applied_wo_d;
   logic        armed_q, armed_d;
   logic        cfg_err_q, cfg_err_d;
   logic        len_err_q, len_err_d;

   logic                       vs_edge;
   logic                       zero_req;
   logic                       div_start;
   logic                       div_done;
   logic [SCALER_DIV_BITS-1:0] div_quo;
   logic [SCALER_DIV_BITS-1:0] dividend;

   assign vs_edge  = vs_i & ~vs_q;
   assign zero_req = (cfg_width_i == 16'd0) || (cfg_width_o == 16'd0);
   assign dividend = SCALER_DIV_BITS'(cfg_width_i) << FRAC_BITS;

   scaler_step_div u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (dividend),
      .divisor_i  (cfg_width_o),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   always_comb begin
      state_d      = state_q;
      pend_step_d  = pend_step_q;
      pend_wo_d    = pend_wo_q;
      step_d       = step_q;
      applied_wo_d = applied_wo_q;
      armed_d      = armed_q;
      cfg_err_d    = cfg_err_q;
      len_err_d    = len_err_q;
      div_start    = 1'b0;

      case (state_q)
         ST_IDLE, ST_PEND: begin
            if (cfg_wr) begin
               cfg_err_d = 1'b0;
               len_err_d = 1'b0;
               if (zero_req) begin
                  cfg_err_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  pend_wo_d = cfg_width_o;
                  div_start = 1'b1;
                  state_d   = ST_DIV;
               end
            end else if (vs_edge && state_q == ST_PEND) begin
               step_d       = pend_step_q;
               applied_wo_d = pend_wo_q;
               armed_d      = 1'b0;
               state_d      = ST_IDLE;
            end else if (vs_edge && applied_wo_q != 16'd0) begin
               // First frame after an apply only arms the check.
               if (armed_q && pix_count_i != applied_wo_q)
                  len_err_d = 1'b1;
               armed_d = 1'b1;
            end
         end
         ST_DIV: begin
            if (div_done) begin
               if (div_quo[SCALER_DIV_BITS-1:16] != '0) begin
                  cfg_err_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  pend_step_d = div_quo[15:0];
                  state_d     = ST_PEND;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vs_q         <= 1'b0;
         pend_step_q  <= '0;
         pend_wo_q    <= '0;
         step_q       <= 16'(STEP_CORD_I);
         applied_wo_q <= '0;
         armed_q      <= 1'b0;
         cfg_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_i;
         pend_step_q  <= pend_step_d;
         pend_wo_q    <= pend_wo_d;
         step_q       <= step_d;
         applied_wo_q <= applied_wo_d;
         armed_q      <= armed_d;
         cfg_err_q    <= cfg_err_d;
         len_err_q    <= len_err_d;
      end
   end

   assign step_cord_o = step_q;
   assign busy_o      = (state_q == ST_DIV);
   assign pend_o      = (state_q == ST_PEND);
   assign cfg_err_o   = cfg_err_q;
   assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Bench for scaler_h_ctrl: vector table, directed corner sequences and random requests
// checked against a ratio-arithmetic model.
module tb_scaler_h_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_wr;
   logic [15:0] wi, wo, pix;
   logic        vs;
   logic [15:0] step_cord_o;
   logic        busy_o, pend_o, cfg_err_o, len_err_o;

   int vectors    = 0;
   int miscompares = 0;

   logic [15:0] model_step;
   logic [15:0] model_pend;
   bit          model_pend_v;

   scaler_h_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (cfg_wr),
      .cfg_width_i (wi),
      .cfg_width_o (wo),
      .vs_i        (vs),
      .pix_count_i (pix),
      .step_cord_o (step_cord_o),
      .busy_o      (busy_o),
      .pend_o      (pend_o),
      .cfg_err_o   (cfg_err_o),
      .len_err_o   (len_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] wi;
      logic [15:0] wo;
      logic [15:0] step;
      bit          err;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it through the divide, checking timing and outcome.
   task automatic run_cfg(input logic [15:0] a, input logic [15:0] b);
      longint q;
      bit     zero, ovf;
      int     nbusy;
      zero = (a == 16'd0) || (b == 16'd0);
      q    = zero ? 0 : (longint'(a) * 4096) / longint'(b);
      ovf  = !zero && (q > 65535);
      model_pend_v = 1'b0;
      wi = a; wo = b; cfg_wr = 1'b1;
      tick;
      cfg_wr = 1'b0;
      chk("cfg_err_e1", cfg_err_o, zero);
      chk("len_err_clr", len_err_o, 0);
      if (zero) begin
         chk("busy_zero", busy_o, 0);
         chk("pend_zero", pend_o, 0);
         return;
      end
      nbusy = busy_o ? 1 : 0;
      for (int k = 2; k <= 28; k++) begin
         tick;
         if (busy_o) nbusy++;
         if (pend_o) nbusy += 100;
      end
      chk("busy_cycles", nbusy, 28);
      tick;
      chk("busy_fall", busy_o, 0);
      chk("pend_rise", pend_o, !ovf);
      chk("cfg_err_ovf", cfg_err_o, ovf);
      if (!ovf) begin
         model_pend   = q[15:0];
         model_pend_v = 1'b1;
      end
   endtask

   task automatic vs_pulse(input logic [15:0] p);
      pix = p;
      vs  = 1'b1;
      chk("step_hold", step_cord_o, model_step);
      tick;
      vs = 1'b0;
      if (model_pend_v) begin
         model_step   = model_pend;
         model_pend_v = 1'b0;
      end
      chk("step_apply", step_cord_o, model_step);
      chk("pend_after_vs", pend_o, 0);
      tick;
   endtask

   initial begin
      rst = 1'b1; cfg_wr = 1'b0; vs = 1'b0;
      wi = '0; wo = '0; pix = '0;
      model_step = 16'd4096; model_pend = '0; model_pend_v = 1'b0;

      tbl[0] = '{wi: 16'd1920, wo: 16'd0,    step: 16'd4096, err: 1'b1};
      tbl[1] = '{wi: 16'd2000, wo: 16'd100,  step: 16'd4096, err: 1'b1};
      tbl[2] = '{wi: 16'd1920, wo: 16'd1280, step: 16'd6144, err: 1'b0};
      tbl[3] = '{wi: 16'd1280, wo: 16'd1920, step: 16'd2730, err: 1'b0};
      tbl[4] = '{wi: 16'd1920, wo: 16'd960,  step: 16'd8192, err: 1'b0};

      tick; tick;
      chk("rst_step", step_cord_o, 4096);
      chk("rst_busy", busy_o, 0);
      chk("rst_pend", pend_o, 0);
      chk("rst_cfg_err", cfg_err_o, 0);
      chk("rst_len_err", len_err_o, 0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < 5; i++) begin
         run_cfg(tbl[i].wi, tbl[i].wo);
         chk("tbl_err", cfg_err_o, tbl[i].err);
         vs_pulse(16'd0);
         chk("tbl_step", step_cord_o, tbl[i].step);
      end

      // cfg_wr during DIV must be ignored
      wi = 16'd1920; wo = 16'd1280; cfg_wr = 1'b1;
      tick;
      cfg_wr = 1'b0;
      repeat (4) tick;
      wo = 16'd960; cfg_wr = 1'b1;
      tick;
      cfg_wr = 1'b0;
      repeat (22) tick;
      chk("div_ign_busy28", busy_o, 1);
      tick;
      chk("div_ign_pend29", pend_o, 1);
      model_pend = 16'd6144; model_pend_v = 1'b1;
      vs_pulse(16'd0);
      chk("div_ign_step", step_cord_o, 6144);

      // second request while pending replaces the first
      run_cfg(16'd1920, 16'd1280);
      repeat (3) tick;
      chk("pend_hold_step", step_cord_o, 6144);
      run_cfg(16'd1920, 16'd960);
      vs_pulse(16'd0);
      chk("pend_replace_step", step_cord_o, 8192);

      // length check arms on the first frame after an apply
      run_cfg(16'd1920, 16'd1280);
      vs_pulse(16'd0);
      vs_pulse(16'd1279);
      chk("len_frame1", len_err_o, 0);
      vs_pulse(16'd1280);
      chk("len_frame2", len_err_o, 0);
      vs_pulse(16'd1279);
      chk("len_frame3", len_err_o, 1);
      vs_pulse(16'd1280);
      chk("len_sticky", len_err_o, 1);
      run_cfg(16'd1920, 16'd1280);
      vs_pulse(16'd1280);

      // random requests, sometimes overlapping a pending step
      for (int n = 0; n < 16; n++) begin
         logic [15:0] a, b;
         a = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 4095));
         b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 4095));
         run_cfg(a, b);
         if ($urandom_range(0, 3) != 0) vs_pulse(16'd0);
      end
      vs_pulse(16'd0);

      // reset in the middle of a divide
      wi = 16'd1920; wo = 16'd1280; cfg_wr = 1'b1;
      tick;
      cfg_wr = 1'b0;
      repeat (9) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_step = 16'd4096; model_pend_v = 1'b0;
      chk("mid_rst_step", step_cord_o, 4096);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_pend", pend_o, 0);
      chk("mid_rst_cfg_err", cfg_err_o, 0);
      vs_pulse(16'd5);
      vs_pulse(16'd5);
      vs_pulse(16'd5);
      chk("mid_rst_step_after", step_cord_o, 4096);
      chk("mid_rst_no_len", len_err_o, 0);
      chk("mid_rst_pend_after", pend_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
